// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB definitions: entry count, TLB op encodings and controller state encoding.
package tlb_op_ctrl_pkg;

    localparam int unsigned TLBNUM    = 32;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned INV_OP_W  = 5;
    localparam int unsigned ASID_W    = 10;
    localparam int unsigned VPN_W     = 19;

    typedef enum logic [OP_W-1:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } op_code_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Codes above INV are reserved and run as a NOP.
    function automatic logic is_legal_op(input logic [OP_W-1:0] code);
        return code <= OP_INV;
    endfunction

    // Ops that change TLB contents and so require a refetch.
    function automatic logic op_changes_tlb(input logic [OP_W-1:0] code);
        return (code == OP_WR) || (code == OP_FILL) || (code == OP_INV);
    endfunction

endpackage

// File: rtl/tlb_rand_idx.sv
// Free-running victim index for TLB FILL; wraps at the entry count.
module tlb_rand_idx #(
    parameter int unsigned TLBNUM = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [$clog2(TLBNUM)-1:0] idx
);

    localparam int unsigned W = $clog2(TLBNUM);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (idx == W'(TLBNUM - 1)) begin
            idx <= '0;
        end else begin
            idx <= idx + W'(1);
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLB instructions: drains outstanding translations, issues one strobe, reports completion.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = tlb_op_ctrl_pkg::TLBNUM
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [2:0]                op_code,
    input  logic [4:0]                inv_op,
    input  logic [9:0]                inv_asid,
    input  logic [18:0]               inv_vpn,
    input  logic                      flush,
    input  logic                      inst_busy,
    input  logic                      data_busy,
    output logic                      trans_block,
    output logic                      tlb_srch_en,
    output logic                      tlb_rd_en,
    output logic                      tlb_wen,
    output logic                      tlb_fill_en,
    output logic                      tlbinv_en,
    output logic [4:0]                tlbinv_op,
    output logic [9:0]                tlbinv_asid,
    output logic [18:0]               tlbinv_vpn,
    output logic [$clog2(TLBNUM)-1:0] rand_index,
    input  logic                      srch_found,
    input  logic [$clog2(TLBNUM)-1:0] srch_index,
    output logic                      done_valid,
    output logic                      done_found,
    output logic [$clog2(TLBNUM)-1:0] done_index,
    output logic                      refetch
);

    import tlb_op_ctrl_pkg::*;

    localparam int unsigned IW = $clog2(TLBNUM);

    state_e               state, state_next;
    logic [OP_W-1:0]      op_q;
    logic [INV_OP_W-1:0]  inv_op_q;
    logic [ASID_W-1:0]    inv_asid_q;
    logic [VPN_W-1:0]     inv_vpn_q;

    logic                 op_ready_d, trans_block_d;
    logic                 srch_en_d, rd_en_d, wen_d, fill_en_d, inv_en_d;
    logic [INV_OP_W-1:0]  tlbinv_op_d;
    logic [ASID_W-1:0]    tlbinv_asid_d;
    logic [VPN_W-1:0]     tlbinv_vpn_d;
    logic                 done_valid_d, done_found_d, refetch_d;
    logic [IW-1:0]        done_index_d;

    tlb_rand_idx #(.TLBNUM(TLBNUM)) u_rand_idx (
        .clk   (clk),
        .reset (reset),
        .idx   (rand_index)
    );

    // Next state, then outputs decoded from the next state so every output is registered.
    always_comb begin
        state_next    = state;
        op_ready_d    = 1'b0;
        trans_block_d = 1'b1;
        srch_en_d     = 1'b0;
        rd_en_d       = 1'b0;
        wen_d         = 1'b0;
        fill_en_d     = 1'b0;
        inv_en_d      = 1'b0;
        tlbinv_op_d   = '0;
        tlbinv_asid_d = '0;
        tlbinv_vpn_d  = '0;
        done_valid_d  = 1'b0;
        refetch_d     = 1'b0;
        done_found_d  = done_found;
        done_index_d  = done_index;

        case (state)
            ST_IDLE:  if (op_valid) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (!inst_busy && !data_busy) begin
                    state_next = is_legal_op(op_q) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: state_next = (op_q == OP_SRCH) ? ST_WAIT : ST_DONE;
            ST_WAIT: begin
                state_next   = ST_DONE;
                done_found_d = srch_found;
                done_index_d = srch_index;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        op_ready_d    = (state_next == ST_IDLE);
        trans_block_d = !op_ready_d;

        if (state_next == ST_ISSUE) begin
            srch_en_d = (op_q == OP_SRCH);
            rd_en_d   = (op_q == OP_RD);
            wen_d     = (op_q == OP_WR);
            fill_en_d = (op_q == OP_FILL);
            if (op_q == OP_INV) begin
                inv_en_d      = 1'b1;
                tlbinv_op_d   = inv_op_q;
                tlbinv_asid_d = inv_asid_q;
                tlbinv_vpn_d  = inv_vpn_q;
            end
        end

        // Search results survive until the next search; any other completion clears them.
        if (state_next == ST_DONE) begin
            done_valid_d = 1'b1;
            refetch_d    = op_changes_tlb(op_q);
            if (state != ST_WAIT) begin
                done_found_d = 1'b0;
                done_index_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            inv_op_q    <= '0;
            inv_asid_q  <= '0;
            inv_vpn_q   <= '0;
            op_ready    <= 1'b1;
            trans_block <= 1'b0;
            tlb_srch_en <= 1'b0;
            tlb_rd_en   <= 1'b0;
            tlb_wen     <= 1'b0;
            tlb_fill_en <= 1'b0;
            tlbinv_en   <= 1'b0;
            tlbinv_op   <= '0;
            tlbinv_asid <= '0;
            tlbinv_vpn  <= '0;
            done_valid  <= 1'b0;
            done_found  <= 1'b0;
            done_index  <= '0;
            refetch     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && op_valid) begin
                op_q       <= op_code;
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vpn_q  <= inv_vpn;
            end
            op_ready    <= op_ready_d;
            trans_block <= trans_block_d;
            tlb_srch_en <= srch_en_d;
            tlb_rd_en   <= rd_en_d;
            tlb_wen     <= wen_d;
            tlb_fill_en <= fill_en_d;
            tlbinv_en   <= inv_en_d;
            tlbinv_op   <= tlbinv_op_d;
            tlbinv_asid <= tlbinv_asid_d;
            tlbinv_vpn  <= tlbinv_vpn_d;
            done_valid  <= done_valid_d;
            done_found  <= done_found_d;
            done_index  <= done_index_d;
            refetch     <= refetch_d;
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with hand-computed expectations.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_ready;
    logic [2:0]  op_code;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vpn;
    logic        flush, inst_busy, data_busy, trans_block;
    logic        tlb_srch_en, tlb_rd_en, tlb_wen, tlb_fill_en, tlbinv_en;
    logic [4:0]  tlbinv_op;
    logic [9:0]  tlbinv_asid;
    logic [18:0] tlbinv_vpn;
    logic [4:0]  rand_index;
    logic        srch_found;
    logic [4:0]  srch_index;
    logic        done_valid, done_found;
    logic [4:0]  done_index;
    logic        refetch;

    int          errors = 0;
    int          checks = 0;
    logic [4:0]  exp_rand = '0;

    tlb_op_ctrl #(.TLBNUM(32)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
        .flush(flush), .inst_busy(inst_busy), .data_busy(data_busy),
        .trans_block(trans_block), .tlb_srch_en(tlb_srch_en), .tlb_rd_en(tlb_rd_en),
        .tlb_wen(tlb_wen), .tlb_fill_en(tlb_fill_en), .tlbinv_en(tlbinv_en),
        .tlbinv_op(tlbinv_op), .tlbinv_asid(tlbinv_asid), .tlbinv_vpn(tlbinv_vpn),
        .rand_index(rand_index), .srch_found(srch_found), .srch_index(srch_index),
        .done_valid(done_valid), .done_found(done_found), .done_index(done_index),
        .refetch(refetch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, track the expected counter, and check strobe exclusivity.
    task automatic step();
        @(posedge clk);
        exp_rand = reset ? 5'd0 : exp_rand + 5'd1;
        #1;
        chk("excl", 32'($countones({tlb_srch_en, tlb_rd_en, tlb_wen, tlb_fill_en,
                                    tlbinv_en, done_valid})), 32'(done_valid ? 1 : 0)
                                    + 32'($countones({tlb_srch_en, tlb_rd_en, tlb_wen,
                                    tlb_fill_en, tlbinv_en}) > 1 ? 9 : 0)
                                    + 32'(done_valid ? 0 : $countones({tlb_srch_en,
                                    tlb_rd_en, tlb_wen, tlb_fill_en, tlbinv_en})));
        chk("rand", 32'(rand_index), 32'(exp_rand));
    endtask

    // Present an op in IDLE; returns in the first DRAIN cycle.
    task automatic offer(input logic [2:0] code);
        chk("ready_pre", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_code  = code;
        step();
        op_valid = 1'b0;
        chk("ready_drain", 32'(op_ready), 32'd0);
        chk("block_drain", 32'(trans_block), 32'd1);
    endtask

    function automatic logic [31:0] strobes();
        return 32'({tlb_srch_en, tlb_rd_en, tlb_wen, tlb_fill_en, tlbinv_en});
    endfunction

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0;
        inv_vpn = '0; flush = 1'b0; inst_busy = 1'b0; data_busy = 1'b0;
        srch_found = 1'b0; srch_index = '0;
        step(); step();
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_block", 32'(trans_block), 32'd0);
        chk("rst_strobes", strobes(), 32'd0);
        chk("rst_inv", 32'({tlbinv_op, tlbinv_asid, tlbinv_vpn}), 32'd0);
        chk("rst_done", 32'({done_valid, done_found, done_index, refetch}), 32'd0);
        reset = 1'b0;
        step();

        // SRCH: strobe at T+2, result at T+4
        offer(3'd0);
        step();
        chk("srch_en", strobes(), 32'b10000);
        srch_found = 1'b1; srch_index = 5'd7;
        step();
        chk("srch_wait", strobes() | 32'(done_valid), 32'd0);
        step();
        srch_found = 1'b0; srch_index = 5'd0;
        chk("srch_dv", 32'(done_valid), 32'd1);
        chk("srch_found", 32'(done_found), 32'd1);
        chk("srch_idx", 32'(done_index), 32'd7);
        chk("srch_refetch", 32'(refetch), 32'd0);
        step();
        chk("srch_idle", 32'(op_ready), 32'd1);
        chk("srch_hold", 32'({done_valid, done_found, done_index}), 32'h27);

        // Reserved op 6: DRAIN then DONE, no strobe
        offer(3'd6);
        step();
        chk("nop_dv", 32'(done_valid), 32'd1);
        chk("nop_strobes", strobes(), 32'd0);
        chk("nop_found", 32'({done_found, done_index}), 32'd0);
        chk("nop_refetch", 32'(refetch), 32'd0);
        step();

        // WR held off by data_busy for 3 cycles
        data_busy = 1'b1;
        offer(3'd2);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wr_block", 32'(trans_block), 32'd1);
            chk("wr_nostrobe", strobes(), 32'd0);
        end
        data_busy = 1'b0;
        step();
        chk("wr_wen", strobes(), 32'b00100);
        chk("wr_block_issue", 32'(trans_block), 32'd1);
        step();
        chk("wr_done", 32'({done_valid, refetch, tlb_wen}), 32'b110);
        step();
        chk("wr_after", 32'({done_valid, refetch, op_ready}), 32'b001);

        // INV with latched operands
        inv_op = 5'd5; inv_asid = 10'h3A; inv_vpn = 19'h1234;
        offer(3'd4);
        inv_op = '0; inv_asid = '0; inv_vpn = '0;
        step();
        chk("inv_en", strobes(), 32'b00001);
        chk("inv_op", 32'(tlbinv_op), 32'd5);
        chk("inv_asid", 32'(tlbinv_asid), 32'h3A);
        chk("inv_vpn", 32'(tlbinv_vpn), 32'h1234);
        step();
        chk("inv_done", 32'({tlbinv_en, done_valid, refetch}), 32'b011);
        chk("inv_ops_clr", 32'({tlbinv_op, tlbinv_asid}), 32'd0);
        step();

        // Flush during DRAIN abandons FILL
        data_busy = 1'b1;
        offer(3'd3);
        flush = 1'b1;
        step();
        flush = 1'b0; data_busy = 1'b0;
        chk("flush_ready", 32'(op_ready), 32'd1);
        chk("flush_block", 32'(trans_block), 32'd0);
        chk("flush_quiet", strobes() | 32'({done_valid, refetch}), 32'd0);
        step();
        chk("flush_quiet2", strobes() | 32'({done_valid, refetch}), 32'd0);

        // FILL with rand_index reaching 31 in ISSUE
        for (int i = 0; i < 40 && exp_rand != 5'd29; i++) step();
        chk("fill_align", 32'(exp_rand), 32'd29);
        offer(3'd3);
        step();
        chk("fill_en", strobes(), 32'b00010);
        chk("fill_idx", 32'(rand_index), 32'd31);
        step();
        chk("fill_wrap", 32'(rand_index), 32'd0);
        chk("fill_done", 32'({done_valid, refetch}), 32'b11);
        step();

        // Reset while in WAIT
        offer(3'd0);
        step();
        srch_found = 1'b1; srch_index = 5'd9;
        step();
        reset = 1'b1;
        step();
        chk("rw_ready", 32'(op_ready), 32'd1);
        chk("rw_block", 32'(trans_block), 32'd0);
        chk("rw_outs", strobes() | 32'({done_valid, done_found, done_index, refetch}), 32'd0);
        chk("rw_rand", 32'(rand_index), 32'd0);
        reset = 1'b0; srch_found = 1'b0; srch_index = '0;
        step();
        chk("rw_exit", strobes() | 32'({done_valid, done_found, done_index, refetch}), 32'd0);
        chk("rw_idle", 32'({op_ready, trans_block}), 32'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 32, the number of TLB entries; the index width is log2(TLBNUM) = 5.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port op_valid, input, 1 bit: a TLB instruction is offered.
REQ-005 SHALL have port op_ready, output, 1 bit: the controller can accept an op.
REQ-006 SHALL have port op_code, input, 3 bits: 0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 are reserved.
REQ-007 SHALL have ports inv_op (5 bits), inv_asid (10 bits) and inv_vpn (19 bits), all inputs: INVTLB operands.
REQ-008 SHALL have port flush, input, 1 bit: pipeline flush (branch, exception or ertn).
REQ-009 SHALL have ports inst_busy and data_busy, inputs, 1 bit each: a translation is outstanding in the instruction or data path.
REQ-010 SHALL have port trans_block, output, 1 bit: gates new inst and data translation requests.
REQ-011 SHALL have ports tlb_srch_en, tlb_rd_en, tlb_wen and tlb_fill_en, outputs, 1 bit each: one-cycle TLB operation strobes.
REQ-012 SHALL have ports tlbinv_en (1 bit), tlbinv_op (5 bits), tlbinv_asid (10 bits) and tlbinv_vpn (19 bits), all outputs: to the TLB invalidate port.
REQ-013 SHALL have port rand_index, output, 5 bits: victim index for FILL.
REQ-014 SHALL have ports srch_found (1 bit) and srch_index (5 bits), inputs: TLB search result, valid one cycle after tlb_srch_en.
REQ-015 SHALL have ports done_valid (1 bit), done_found (1 bit) and done_index (5 bits), outputs: op completion and search result.
REQ-016 SHALL have port refetch, output, 1 bit: one-cycle request to refetch after the TLB contents change.

Function
REQ-017 SHALL implement the states IDLE, DRAIN, ISSUE, WAIT and DONE.
REQ-018 SHALL drive op_ready=1 only in IDLE; on op_valid&op_ready it SHALL latch op_code and the inv operands and go to DRAIN.
REQ-019 SHALL drive trans_block=1 in every state other than IDLE.
REQ-020 SHALL move from DRAIN to ISSUE in the first cycle in which inst_busy=0 and data_busy=0, and SHALL remain in DRAIN otherwise.
REQ-021 SHALL, when flush=1 in DRAIN, return to IDLE with no strobe, no done_valid and no refetch; flush has priority over the busy check.
REQ-022 SHALL ignore flush in ISSUE, WAIT and DONE, because the op is committed.
REQ-023 SHALL, in ISSUE, assert for exactly one cycle the strobe matching the latched op; INV drives tlbinv_op/asid/vpn from the latched values; SRCH goes to WAIT, every other op goes to DONE.
REQ-024 SHALL, in WAIT, capture srch_found and srch_index into done_found and done_index, then go to DONE.
REQ-025 SHALL, in DONE, drive done_valid=1 for one cycle and then return to IDLE.
REQ-026 SHALL drive refetch=1 in DONE only for WR, FILL and INV.
REQ-027 SHALL hold done_found and done_index until the next SRCH capture, and SHALL clear them to 0 at DONE of every non-SRCH op.
REQ-028 SHALL treat reserved op codes as NOP: the sequence DRAIN then DONE, with no ISSUE strobe, done_found=0 and no refetch.
REQ-029 SHALL make rand_index a free-running 5-bit counter that increments every non-reset cycle and wraps from 31 to 0; FILL uses its value in the ISSUE cycle.
REQ-030 SHALL meet this latency with busy low: accept at cycle T, ISSUE at T+2, DONE at T+3 (SRCH: WAIT at T+3, DONE at T+4); the next op can be accepted at DONE+1.
REQ-031 SHALL keep all strobes, done_valid and refetch mutually exclusive in time and never asserted outside the state that defines them.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, enter IDLE, abandoning any op in flight with no strobe, done_valid or refetch in the following cycle.
REQ-033 SHALL drive these values while in reset and at reset exit: op_ready=1, trans_block=0, all strobes and tlbinv_* = 0, rand_index=0, done_valid=0, done_found=0, done_index=0, refetch=0.

Structure
REQ-034 SHALL take the op code enum (SRCH/RD/WR/FILL/INV), the state enum and TLBNUM from the shared package, which the TLB and decode stage also import.
REQ-035 SHALL place the random-index counter in one sub-module, tlb_rand_idx; the FSM and output decode stay in tlb_op_ctrl.

Verification
REQ-036 SHALL cover SRCH with busy low and srch_found=1, srch_index=7 from the TLB -> tlb_srch_en at T+2, done_valid at T+4 with done_found=1, done_index=7, refetch=0.
REQ-037 SHALL cover WR with data_busy held high 3 cycles after accept -> trans_block=1 throughout, tlb_wen one cycle after busy drops, then done_valid and refetch together for one cycle.
REQ-038 SHALL cover INV with inv_op=5, inv_asid=0x3A, inv_vpn=0x1234 -> tlbinv_en for one cycle with those exact operand values, then refetch=1.
REQ-039 SHALL cover flush asserted while in DRAIN on a FILL -> return to IDLE, no tlb_fill_en, no done_valid, op_ready=1 in the next cycle.
REQ-040 SHALL cover FILL issued when rand_index=31 -> tlb_fill_en with rand_index=31 and rand_index=0 in the next cycle.
REQ-041 SHALL cover reset asserted in WAIT, and op_code=6 -> reset gives IDLE with all outputs at reset values and no done_valid; op_code=6 gives done_valid with done_found=0, no strobe and no refetch.
